// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM sequence controller: state encoding and default
// sequence geometry.
package lstm_pkg;

  localparam int NUM_DEFAULT      = 68;
  localparam int NUM_ITER_DEFAULT = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_LABEL = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    FEED  = S_FEED,
    LABEL = S_LABEL,
    FIN   = S_FIN
  } state_t;

  // Counter width with a floor of one bit so degenerate sizes still elaborate
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lstm_seq_ctrl.sv
// Walks one LSTM input sequence: NUM feature addresses per timestep, then that
// step's label address, for NUM_ITERATIONS timesteps, using valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for start
// FEED  | issuing feature addresses base+feat
// LABEL | issuing label address iter
// FIN   | one-cycle done pulse, back to IDLE
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int NUM            = NUM_DEFAULT,
  parameter int NUM_ITERATIONS = NUM_ITER_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] x_addr,
  output logic             x_valid,
  input  logic             x_ready,
  output logic [WIDTH-1:0] y_addr,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             step_done,
  output logic             busy,
  output logic             done
);

  localparam int FW = cnt_w(NUM);
  localparam int IW = cnt_w(NUM_ITERATIONS);
  localparam int BW = cnt_w(NUM * NUM_ITERATIONS);

  localparam logic [FW-1:0] FEAT_LAST = FW'(NUM - 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(NUM_ITERATIONS - 1);
  localparam logic [BW-1:0] NUM_B     = BW'(NUM);

  state_t        state_q, state_d;
  logic [FW-1:0] feat_q, feat_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [BW-1:0] base_q, base_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      feat_q  <= '0;
      iter_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      iter_q  <= iter_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    feat_d    = feat_q;
    iter_d    = iter_q;
    base_d    = base_q;
    x_addr    = '0;
    x_valid   = 1'b0;
    y_addr    = '0;
    y_valid   = 1'b0;
    step_done = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FEED;
          feat_d  = '0;
          iter_d  = '0;
          base_d  = '0;
        end
      end

      FEED: begin
        busy    = 1'b1;
        x_valid = 1'b1;
        x_addr  = WIDTH'(base_q) + WIDTH'(feat_q);
        if (abort) begin
          state_d = IDLE;
        end else if (x_ready) begin
          if (feat_q == FEAT_LAST) state_d = LABEL;
          else                     feat_d  = feat_q + 1'b1;
        end
      end

      LABEL: begin
        busy    = 1'b1;
        y_valid = 1'b1;
        y_addr  = WIDTH'(iter_q);
        // abort outranks a simultaneous acceptance: no step credit is given
        if (abort) begin
          state_d = IDLE;
        end else if (y_ready) begin
          step_done = 1'b1;
          feat_d    = '0;
          base_d    = base_q + NUM_B;
          iter_d    = iter_q + 1'b1;
          state_d   = (iter_q == ITER_LAST) ? FIN : FEED;
        end
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Directed table of per-cycle vectors on a small (NUM=3, 2 steps) controller, plus a
// random-ready full-length run on a default-sized controller.
module tb_lstm_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance
  logic        rst, start, abort, x_ready, y_ready;
  logic [31:0] x_addr, y_addr;
  logic        x_valid, y_valid, step_done, busy, done;

  // default-sized instance
  logic        rst2, start2, abort2, x_ready2, y_ready2;
  logic [31:0] x_addr2, y_addr2;
  logic        x_valid2, y_valid2, step_done2, busy2, done2;

  lstm_seq_ctrl #(.WIDTH(32), .NUM(3), .NUM_ITERATIONS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x_addr(x_addr), .x_valid(x_valid), .x_ready(x_ready),
    .y_addr(y_addr), .y_valid(y_valid), .y_ready(y_ready),
    .step_done(step_done), .busy(busy), .done(done)
  );

  lstm_seq_ctrl dut2 (
    .clk(clk), .rst(rst2), .start(start2), .abort(abort2),
    .x_addr(x_addr2), .x_valid(x_valid2), .x_ready(x_ready2),
    .y_addr(y_addr2), .y_valid(y_valid2), .y_ready(y_ready2),
    .step_done(step_done2), .busy(busy2), .done(done2)
  );

  typedef struct {
    bit       rst, start, abort, xr, yr;
    bit       xv;
    bit [31:0] xa;
    bit       yv;
    bit [31:0] ya;
    bit       sd, bz, dn;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic v(input bit r, input bit s, input bit a, input bit xr, input bit yr,
                   input bit xv, input int xa, input bit yv, input int ya,
                   input bit sd, input bit bz, input bit dn);
    vec_t t;
    t.rst = r; t.start = s; t.abort = a; t.xr = xr; t.yr = yr;
    t.xv = xv; t.xa = 32'(xa); t.yv = yv; t.ya = 32'(ya);
    t.sd = sd; t.bz = bz; t.dn = dn;
    vecs.push_back(t);
  endtask

  // inputs only, all outputs expected zero (IDLE)
  task automatic vi(input bit r, input bit s, input bit a);
    v(r, s, a, 1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic vx(input bit s, input bit a, input bit xr, input int xa);
    v(1, s, a, xr, 1, 1, xa, 0, 0, 0, 1, 0);
  endtask

  task automatic vy(input bit a, input bit yr, input int ya, input bit sd);
    v(1, 0, a, 1, yr, 0, 0, 1, ya, sd, 1, 0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [69:0] act, exp;
    int xcnt, ycnt, dcnt, lastx, lasty, cyc;
    bit finished;

    rst = 0; start = 0; abort = 0; x_ready = 0; y_ready = 0;
    rst2 = 0; start2 = 0; abort2 = 0; x_ready2 = 0; y_ready2 = 0;

    // A: nominal run, done 9 cycles after start
    vi(0, 0, 0);
    vi(1, 1, 0);
    vx(0, 0, 1, 0); vx(0, 0, 1, 1); vx(0, 0, 1, 2);
    vy(0, 1, 0, 1);
    vx(0, 0, 1, 3); vx(0, 0, 1, 4); vx(0, 0, 1, 5);
    vy(0, 1, 1, 1);
    v(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    vi(1, 0, 0);
    // B: x stall at feat 1, y stall, restart ignored while busy, abort in FIN ignored
    vi(1, 1, 0);
    vx(1, 0, 1, 0);
    vx(0, 0, 0, 1); vx(0, 0, 0, 1); vx(0, 0, 0, 1);
    vx(0, 0, 1, 1);
    vx(1, 0, 1, 2);
    vy(0, 0, 0, 0);
    vy(0, 1, 0, 1);
    vx(1, 0, 1, 3); vx(0, 0, 1, 4); vx(0, 0, 1, 5);
    vy(0, 1, 1, 1);
    v(1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    vi(1, 0, 0);
    vi(1, 0, 0);
    // C: abort in LABEL, start beats abort in IDLE, abort in FEED, abort in IDLE inert
    vi(1, 1, 0);
    vx(0, 0, 1, 0); vx(0, 0, 1, 1); vx(0, 0, 1, 2);
    vy(1, 1, 0, 0);
    vi(1, 1, 1);
    vx(0, 1, 1, 0);
    vi(1, 0, 1);
    vi(1, 0, 0);
    // D: reset while x_addr is 4, then restart from 0
    vi(1, 1, 0);
    vx(0, 0, 1, 0); vx(0, 0, 1, 1); vx(0, 0, 1, 2);
    vy(0, 1, 0, 1);
    vx(0, 0, 1, 3);
    v(0, 0, 0, 1, 1, 1, 4, 0, 0, 0, 1, 0);
    vi(1, 0, 0);
    vi(1, 1, 0);
    vx(0, 0, 1, 0);
    vx(0, 1, 1, 1);
    vi(1, 0, 0);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; start = vecs[i].start; abort = vecs[i].abort;
      x_ready = vecs[i].xr; y_ready = vecs[i].yr;
      #1;
      act = {x_valid, x_addr, y_valid, y_addr, step_done, busy, done};
      exp = {vecs[i].xv, vecs[i].xa, vecs[i].yv, vecs[i].ya,
             vecs[i].sd, vecs[i].bz, vecs[i].dn};
      chk($sformatf("vec%0d", i), 64'(act[69:6]), 64'(exp[69:6]));
      chk($sformatf("vec%0d_flags", i), 64'(act[5:0]), 64'(exp[5:0]));
    end

    // full-length default geometry with random ready
    @(negedge clk); rst2 = 1;
    @(negedge clk); start2 = 1;
    xcnt = 0; ycnt = 0; dcnt = 0; lastx = -1; lasty = -1; finished = 0;
    for (cyc = 0; cyc < 6000 && !finished; cyc++) begin
      @(negedge clk);
      start2 = 0;
      x_ready2 = 1'($urandom_range(0, 1));
      y_ready2 = 1'($urandom_range(0, 1));
      #1;
      if (x_valid2 && x_ready2) begin
        chk("x_seq", 64'(x_addr2), 64'(xcnt));
        lastx = int'(x_addr2);
        xcnt++;
      end
      if (y_valid2 && y_ready2) begin
        chk("y_seq", 64'(y_addr2), 64'(ycnt));
        lasty = int'(y_addr2);
        ycnt++;
      end
      if (!x_valid2 && x_addr2 != 0) chk("x_addr_idle_zero", 64'(x_addr2), 64'd0);
      if (!y_valid2 && y_addr2 != 0) chk("y_addr_idle_zero", 64'(y_addr2), 64'd0);
      if (done2) begin
        dcnt++;
        finished = 1;
      end
    end
    if (!finished) chk("full_run_timeout", 64'd0, 64'd1);
    repeat (4) begin
      @(negedge clk);
      #1;
      if (done2) dcnt++;
    end
    chk("x_handshakes", 64'(xcnt), 64'd544);
    chk("last_x_addr", 64'(lastx), 64'd543);
    chk("y_handshakes", 64'(ycnt), 64'd8);
    chk("last_y_addr", 64'(lasty), 64'd7);
    chk("done_pulses", 64'(dcnt), 64'd1);
    chk("busy_after", 64'(busy2), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lstm_seq_ctrl.md
LSTM_SEQ_CTRL -- requirements
Module: lstm_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: address width.
REQ-002 SHALL have parameter NUM, default 68: number of features + 1 per timestep.
REQ-003 SHALL have parameter NUM_ITERATIONS, default 8: number of timesteps per sequence.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1: one-cycle request to run one sequence.
REQ-007 SHALL have port abort, input, 1: terminate the current sequence.
REQ-008 SHALL have port x_addr, output, WIDTH: input-memory address, iter*NUM + feat.
REQ-009 SHALL have port x_valid, output, 1: x_addr holds a valid feature address.
REQ-010 SHALL have port x_ready, input, 1: the datapath accepts the feature.
REQ-011 SHALL have port y_addr, output, WIDTH: label-memory address, equal to iter.
REQ-012 SHALL have port y_valid, output, 1: y_addr holds a valid label address.
REQ-013 SHALL have port y_ready, input, 1: the datapath accepts the label.
REQ-014 SHALL have port step_done, output, 1: one-cycle pulse per completed timestep.
REQ-015 SHALL have port busy, output, 1: high while a sequence is active.
REQ-016 SHALL have port done, output, 1: one-cycle pulse when a sequence completes.

Function
REQ-017 SHALL implement FSM states IDLE, FEED, LABEL and FIN.
REQ-018 IDLE: on start, SHALL clear iter, feat and base to 0 and go to FEED next cycle; busy rises the same cycle as FEED is entered.
REQ-019 FEED: SHALL drive x_valid=1 and x_addr=base+feat. On x_valid&&x_ready, SHALL increment feat. At feat==NUM-1 with acceptance, SHALL go to LABEL.
REQ-020 LABEL: SHALL drive y_valid=1 and y_addr=iter. On y_valid&&y_ready, SHALL pulse step_done, base+=NUM, feat=0, iter+=1. If the accepted iter was NUM_ITERATIONS-1, SHALL go to FIN; otherwise SHALL go to FEED.
REQ-021 FIN: SHALL pulse done for exactly one cycle, drop busy and return to IDLE.
REQ-022 Valid/ready: while valid=1 and ready=0, address and valid SHALL hold stable; valid SHALL never drop without acceptance except on abort or reset.
REQ-023 base SHALL be a running accumulator; no multiplier. Counters SHALL be sized by $clog2 and zero-extended to WIDTH on the outputs.
REQ-024 x_addr and y_addr SHALL be 0 whenever the matching valid is 0.
REQ-025 start while busy SHALL be ignored; it is neither queued nor restarts the sequence.
REQ-026 abort in FEED or LABEL SHALL return the FSM to IDLE on the next edge, with no done and no step_done that cycle, even if ready is high.
REQ-027 abort and start both high in IDLE: start SHALL win. abort in IDLE or FIN SHALL have no effect.
REQ-028 The last address issued SHALL be x_addr = NUM_ITERATIONS*NUM-1 and y_addr = NUM_ITERATIONS-1; nothing beyond these.

Reset
REQ-029 With rst=0 at a clock edge, SHALL enter IDLE and drive x_valid, y_valid, step_done, busy, done = 0 and x_addr, y_addr = 0, with counters cleared.
REQ-030 Reset mid-sequence SHALL discard progress. The next start SHALL begin at iter 0, feat 0.

Structure
REQ-031 State encoding localparams and the default NUM/NUM_ITERATIONS values SHALL reside in a shared package, lstm_pkg.
REQ-032 SHALL be a single module with no sub-modules; the counters are inline.

Verification (NUM=3, NUM_ITERATIONS=2 unless stated)
REQ-033 Stimulus: start pulse; x_ready=1 and y_ready=1 throughout. Response: x_addr 0,1,2, then y_addr 0, then x_addr 3,4,5, then y_addr 1; step_done pulses twice; done pulses once, 9 cycles after start.
REQ-034 Stimulus: x_ready low for 3 cycles at feat 1. Response: x_addr holds 1 with x_valid=1 for all 3 cycles, then advances to 2.
REQ-035 Stimulus: abort during LABEL of iter 0 with y_ready=1. Response: no step_done, no done; IDLE next cycle; a following start issues x_addr 0.
REQ-036 Stimulus: rst=0 at x_addr 4. Response: all outputs 0 next cycle; a new start issues x_addr 0.
REQ-037 Stimulus: start pulsed again during FEED. Response: sequence unaffected; exactly one done.
REQ-038 Stimulus: defaults, random ready. Response: 544 x handshakes, last x_addr 543; 8 y handshakes, last y_addr 7.
